word_byte_sched: RTL

WORD_BYTE_SCHED -- requirements
Module: word_byte_sched

---
 rtl/wbs_pkg.sv | 26 ++
 rtl/wbs_rr_arb.sv | 20 ++
 rtl/word_byte_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wbs_pkg.sv
// Shared types and widths for the word-to-byte scheduler.
package wbs_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } wbs_state_e;

  typedef logic wbs_src_t;

  localparam wbs_src_t SRC_CH0 = 1'b0;
  localparam wbs_src_t SRC_CH1 = 1'b1;

  function automatic logic [BYTE_W-1:0] hi_byte(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: BYTE_W];
  endfunction

  function automatic logic [BYTE_W-1:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/wbs_rr_arb.sv
// Two-way round-robin arbiter: on a tie the channel not granted last wins.
module wbs_rr_arb
  import wbs_pkg::*;
(
  input  logic [1:0] req,
  input  wbs_src_t   last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == SRC_CH1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/word_byte_sched.sv
// Two-channel 16-bit word to byte-stream scheduler with round-robin input arbitration.
// Define WBS_LOW_BYTE_EN to emit both bytes per word; otherwise only the high byte is sent.
module word_byte_sched
  import wbs_pkg::*;
#(
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [WORD_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_src,
  output logic              out_last,
  output logic              busy
);

  wbs_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  wbs_src_t          src_q, src_d;
  wbs_src_t          last_q, last_d;

  logic [1:0] gnt;
  logic [1:0] in_ready;
  logic       accept;
  logic       xfer;

  wbs_rr_arb u_arb (
    .req  ({in1_valid, in0_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // The word slot frees up on the edge its final byte leaves, so the next word
  // can be taken in that same cycle; reset gates ready off combinationally.
  always_comb begin
    accept = 1'b0;
    case (state_q)
      ST_IDLE: accept = 1'b1;
`ifdef WBS_LOW_BYTE_EN
      ST_LO:   accept = out_ready;
`else
      ST_HI:   accept = out_ready;
`endif
      default: accept = 1'b0;
    endcase
  end

  assign in_ready  = (accept && rst_n) ? gnt : 2'b00;
  assign in0_ready = in_ready[0];
  assign in1_ready = in_ready[1];
  assign xfer      = |in_ready;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    src_d   = src_q;
    last_d  = last_q;
    case (state_q)
`ifdef WBS_LOW_BYTE_EN
      ST_HI:   if (out_ready) state_d = ST_LO;
      ST_LO:   if (out_ready) state_d = ST_IDLE;
`else
      ST_HI:   if (out_ready) state_d = ST_IDLE;
`endif
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (xfer) begin
      state_d = ST_HI;
      word_d  = gnt[1] ? in1_data : in0_data;
      src_d   = gnt[1] ? SRC_CH1 : SRC_CH0;
      last_d  = gnt[1] ? SRC_CH1 : SRC_CH0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      src_q   <= SRC_CH0;
      last_q  <= ~PRIO_RESET;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state_q)
      ST_HI: begin
        out_data = hi_byte(word_q);
`ifdef WBS_LOW_BYTE_EN
        out_last = 1'b0;
`else
        out_last = 1'b1;
`endif
      end
`ifdef WBS_LOW_BYTE_EN
      ST_LO: begin
        out_data = lo_byte(word_q);
        out_last = 1'b1;
      end
`endif
      default: begin
        out_data = '0;
        out_last = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = busy;
  assign out_src   = busy ? src_q : SRC_CH0;

endmodule
